tnoc_flit_serializer: RTL
=========================

// Module: tnoc_flit_serializer
// PURPOSE
//  Packet-to-flit converter at the NIC/router ingress. Holds one packed header
//  (tnoc_packed_header layout) and emits it as HEADER_FLITS head/body flits,
//  then forwards payload beats one flit each, marking head/tail.
//  Output is a tnoc_flit {data, tail, head, flit_type} on a valid/ready link
//  that feeds the router input FIFO.
// PARAMETERS
//  FLIT_DATA_WIDTH  64   flit data field width
//  HEADER_WIDTH     128  packed header width
//  PAYLOAD_WIDTH    64   packed payload width; must be <= FLIT_DATA_WIDTH (elab $error otherwise)
//  HEADER_FLITS = ceil(HEADER_WIDTH/FLIT_DATA_WIDTH) (localparam, 2 at defaults)
// PORTS
//  i_clk             in   1                  clock
//  i_rst             in   1                  synchronous reset, active-high
//  i_header_valid    in   1                  header offered
//  o_header_ready    out  1                  header accepted when valid&ready
//  i_header          in   HEADER_WIDTH       packed header
//  i_header_only     in   1                  1: packet has no payload
//  i_payload_valid   in   1                  payload beat offered
//  o_payload_ready   out  1                  payload beat accepted when valid&ready
//  i_payload         in   PAYLOAD_WIDTH      packed payload
//  i_payload_last    in   1                  last payload beat of packet
//  o_flit_valid      out  1                  flit offered
//  i_flit_ready      in   1                  flit accepted when valid&ready
//  o_flit            out  FLIT_DATA_WIDTH+3  {data, tail, head, flit_type}
// BEHAVIOUR
//  Clock i_clk; i_rst synchronous active-high. Reset: state=IDLE, beat_cnt=0,
//   header reg=0. While in IDLE: o_flit_valid=0, o_payload_ready=0, o_header_ready=1.
//  FSM states: IDLE, HEADER, PAYLOAD.
//   IDLE: o_header_ready=1. On i_header_valid: latch i_header, i_header_only.
//    Then go to HEADER with beat_cnt=0.
//   HEADER: o_flit_valid=1, o_header_ready=0.
//    o_flit.data = header[beat_cnt*FW +: FW], LSB slice first.
//    Bits beyond HEADER_WIDTH in the final slice are zero.
//    flit_type=0 (header). head=(beat_cnt==0).
//    tail=(beat_cnt==HEADER_FLITS-1) && header_only.
//    On i_flit_ready: beat_cnt++.
//     Last slice + header_only -> IDLE.
//     Last slice + !header_only -> PAYLOAD.
//   PAYLOAD: combinational pass-through, no added latency.
//    o_flit_valid=i_payload_valid; o_payload_ready=i_flit_ready.
//    data = zero-extended i_payload; flit_type=1; head=0; tail=i_payload_last.
//    On a handshake with i_payload_last=1 -> IDLE.
//  Latency: header handshake in cycle T -> first header flit valid in T+1.
//   Unstalled packet with P payload beats: HEADER_FLITS+P flit cycles.
//   Next header accepted in the cycle after the tail handshake.
//   Minimum 1 idle cycle on the link between packets.
//  Stability: in HEADER, o_flit is held until accepted, regardless of i_header*.
//   In PAYLOAD, stability relies on upstream holding the payload beat until ready.
//  Payload before header: o_payload_ready stays 0 outside PAYLOAD.
//   Beats are never consumed early.
//  i_header_valid while busy: ignored (ready=0). Header reg is not overwritten.
//  i_rst mid-packet: next edge forces IDLE.
//   The partial packet is dropped; no tail is emitted. Downstream is reset too.
//  beat_cnt is $clog2(HEADER_FLITS)+1 bits wide and never wraps.
//   It clears on entry to HEADER.
//  HEADER_FLITS=1 is legal: the single flit has head=1 and tail=header_only.
// TESTING
//  1 Header-only: header=128'hA..5, header_only=1, ready=1
//    -> 2 flits: {head=1,tail=0,data=h[63:0]}, {head=0,tail=1,data=h[127:64]}; IDLE.
//  2 Header + 3 payload beats, i_flit_ready toggling 1/0
//    -> 5 flits in order; tail only on beat 3; o_flit stable across each stall.
//  3 Payload valid 4 cycles before header
//    -> o_payload_ready=0 until PAYLOAD; payload flits then follow the 2 header flits.
//  4 Two back-to-back packets (1 and 2 payload beats)
//    -> 2nd o_header_ready rises the cycle after the 1st tail; exactly 1 head per packet.
//  5 i_rst pulsed during payload beat 2 of 4
//    -> o_flit_valid=0 and o_header_ready=1 next cycle; a new packet then serialises cleanly.
//  6 HEADER_WIDTH=100 -> 2nd header flit data[63:36]==0; PAYLOAD_WIDTH=72 -> elaboration error.

Source files
------------

// File: rtl/tnoc_flit_serializer.sv
// Packet-to-flit converter: emits a latched packed header as HEADER_FLITS flits,
// then passes payload beats straight through as one flit each.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a header; header_ready=1, link idle
// HEADER  | sending header slices LSB first, beat_cnt selects the slice
// PAYLOAD | combinational pass-through of payload beats until last beat
module tnoc_flit_serializer #(
  parameter int FLIT_DATA_WIDTH = 64,
  parameter int HEADER_WIDTH    = 128,
  parameter int PAYLOAD_WIDTH   = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_header_valid,
  output logic                       o_header_ready,
  input  logic [HEADER_WIDTH-1:0]    i_header,
  input  logic                       i_header_only,
  input  logic                       i_payload_valid,
  output logic                       o_payload_ready,
  input  logic [PAYLOAD_WIDTH-1:0]   i_payload,
  input  logic                       i_payload_last,
  output logic                       o_flit_valid,
  input  logic                       i_flit_ready,
  output logic [FLIT_DATA_WIDTH+2:0] o_flit
);

  localparam int FW           = FLIT_DATA_WIDTH;
  localparam int HEADER_FLITS = (HEADER_WIDTH + FW - 1) / FW;
  localparam int PAD_W        = HEADER_FLITS * FW;
  localparam int CNT_W        = $clog2(HEADER_FLITS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(HEADER_FLITS - 1);

  if (PAYLOAD_WIDTH > FLIT_DATA_WIDTH) begin : g_bad_payload_width
    $error("tnoc_flit_serializer: PAYLOAD_WIDTH must not exceed FLIT_DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] beat_cnt;
  logic [PAD_W-1:0] header_q;
  logic             header_only_q;
  logic [FW-1:0]    hdr_data;
  logic             last_beat;
  logic [FW-1:0]    flit_data;
  logic             flit_tail;
  logic             flit_head;
  logic             flit_type;

  // header_q is zero-padded to a whole number of flits, so the top slice
  // carries zeros above HEADER_WIDTH.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      beat_cnt      <= '0;
      header_q      <= '0;
      header_only_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && i_header_valid) begin
        header_q      <= PAD_W'(i_header);
        header_only_q <= i_header_only;
        beat_cnt      <= '0;
      end else if (state_q == HEADER && i_flit_ready) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    hdr_data = '0;
    for (int i = 0; i < HEADER_FLITS; i++) begin
      if (beat_cnt == CNT_W'(i)) hdr_data = header_q[i*FW +: FW];
    end
  end

  assign last_beat = (beat_cnt == LAST_BEAT);

  always_comb begin
    state_d         = state_q;
    o_header_ready  = 1'b0;
    o_payload_ready = 1'b0;
    o_flit_valid    = 1'b0;
    flit_data       = '0;
    flit_tail       = 1'b0;
    flit_head       = 1'b0;
    flit_type       = 1'b0;
    case (state_q)
      IDLE: begin
        o_header_ready = 1'b1;
        if (i_header_valid) state_d = HEADER;
      end
      HEADER: begin
        o_flit_valid = 1'b1;
        flit_data    = hdr_data;
        flit_head    = (beat_cnt == '0);
        flit_tail    = last_beat && header_only_q;
        if (i_flit_ready && last_beat) state_d = header_only_q ? IDLE : PAYLOAD;
      end
      PAYLOAD: begin
        o_flit_valid    = i_payload_valid;
        o_payload_ready = i_flit_ready;
        flit_data       = FW'(i_payload);
        flit_type       = 1'b1;
        flit_tail       = i_payload_last;
        if (i_payload_valid && i_flit_ready && i_payload_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_flit = {flit_data, flit_tail, flit_head, flit_type};

endmodule
